// File: rtl/arrow_ctrl_pkg.sv
// Shared VGA/UI constants for the arrow overlay: region codes, UI rectangle
// bounds (inclusive, screen Y grows downward) and default screen limits.
package arrow_ctrl_pkg;

  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_LEVEL   = 3'd1,
    REG_RETRY   = 3'd2,
    REG_RETRACT = 3'd3,
    REG_NEXT    = 3'd4,
    REG_STEP    = 3'd5,
    REG_MESSAGE = 3'd6
  } region_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } click_state_e;

  localparam int unsigned DEF_X_MAX = 783;
  localparam int unsigned DEF_Y_MAX = 583;
  localparam int unsigned DEF_X_RST = 384;
  localparam int unsigned DEF_Y_RST = 284;

  typedef struct packed {
    logic [9:0] left;
    logic [9:0] right;
    logic [9:0] up;
    logic [9:0] down;
  } rect_t;

  localparam logic [9:0] UI_EN_LEVEL_LEFT    = 10'd16;
  localparam logic [9:0] UI_EN_LEVEL_RIGHT   = 10'd127;
  localparam logic [9:0] UI_EN_LEVEL_UP      = 10'd16;
  localparam logic [9:0] UI_EN_LEVEL_DOWN    = 10'd47;
  localparam logic [9:0] UI_EN_RETRY_LEFT    = 10'd640;
  localparam logic [9:0] UI_EN_RETRY_RIGHT   = 10'd767;
  localparam logic [9:0] UI_EN_RETRY_UP      = 10'd16;
  localparam logic [9:0] UI_EN_RETRY_DOWN    = 10'd47;
  localparam logic [9:0] UI_EN_RETRACT_LEFT  = 10'd16;
  localparam logic [9:0] UI_EN_RETRACT_RIGHT = 10'd127;
  localparam logic [9:0] UI_EN_RETRACT_UP    = 10'd536;
  localparam logic [9:0] UI_EN_RETRACT_DOWN  = 10'd567;
  localparam logic [9:0] UI_EN_NEXT_LEFT     = 10'd640;
  localparam logic [9:0] UI_EN_NEXT_RIGHT    = 10'd767;
  localparam logic [9:0] UI_EN_NEXT_UP       = 10'd536;
  localparam logic [9:0] UI_EN_NEXT_DOWN     = 10'd567;
  localparam logic [9:0] UI_EN_STEP_LEFT     = 10'd320;
  localparam logic [9:0] UI_EN_STEP_RIGHT    = 10'd463;
  localparam logic [9:0] UI_EN_STEP_UP       = 10'd536;
  localparam logic [9:0] UI_EN_STEP_DOWN     = 10'd567;
  // The message banner deliberately overlaps the RETRY button.
  localparam logic [9:0] UI_EN_MESSAGE_LEFT  = 10'd600;
  localparam logic [9:0] UI_EN_MESSAGE_RIGHT = 10'd783;
  localparam logic [9:0] UI_EN_MESSAGE_UP    = 10'd0;
  localparam logic [9:0] UI_EN_MESSAGE_DOWN  = 10'd79;

  localparam rect_t RECT_LEVEL   = '{UI_EN_LEVEL_LEFT, UI_EN_LEVEL_RIGHT,
                                     UI_EN_LEVEL_UP, UI_EN_LEVEL_DOWN};
  localparam rect_t RECT_RETRY   = '{UI_EN_RETRY_LEFT, UI_EN_RETRY_RIGHT,
                                     UI_EN_RETRY_UP, UI_EN_RETRY_DOWN};
  localparam rect_t RECT_RETRACT = '{UI_EN_RETRACT_LEFT, UI_EN_RETRACT_RIGHT,
                                     UI_EN_RETRACT_UP, UI_EN_RETRACT_DOWN};
  localparam rect_t RECT_NEXT    = '{UI_EN_NEXT_LEFT, UI_EN_NEXT_RIGHT,
                                     UI_EN_NEXT_UP, UI_EN_NEXT_DOWN};
  localparam rect_t RECT_STEP    = '{UI_EN_STEP_LEFT, UI_EN_STEP_RIGHT,
                                     UI_EN_STEP_UP, UI_EN_STEP_DOWN};
  localparam rect_t RECT_MESSAGE = '{UI_EN_MESSAGE_LEFT, UI_EN_MESSAGE_RIGHT,
                                     UI_EN_MESSAGE_UP, UI_EN_MESSAGE_DOWN};

  function automatic logic in_rect(input logic [9:0] x, input logic [9:0] y,
                                   input rect_t r);
    return (x >= r.left) && (x <= r.right) && (y >= r.up) && (y <= r.down);
  endfunction

endpackage

// File: rtl/arrow_region_decode.sv
// Combinational map from an arrow position to the UI region code under it;
// on overlap the lowest nonzero code wins.
module arrow_region_decode
  import arrow_ctrl_pkg::*;
(
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic [2:0] region
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    region = REG_NONE;
    if (in_rect(pos_x, pos_y, RECT_LEVEL))        region = REG_LEVEL;
    else if (in_rect(pos_x, pos_y, RECT_RETRY))   region = REG_RETRY;
    else if (in_rect(pos_x, pos_y, RECT_RETRACT)) region = REG_RETRACT;
    else if (in_rect(pos_x, pos_y, RECT_NEXT))    region = REG_NEXT;
    else if (in_rect(pos_x, pos_y, RECT_STEP))    region = REG_STEP;
    else if (in_rect(pos_x, pos_y, RECT_MESSAGE)) region = REG_MESSAGE;
  end

endmodule

// File: rtl/arrow_ctrl.sv
// Mouse-arrow cursor controller: clamped position accumulation, frame-synced
// commit (macro ARROW_FRAME_SYNC_EN) and left-click commands with handshake.
module arrow_ctrl
  import arrow_ctrl_pkg::*;
#(
  parameter int unsigned X_MAX = DEF_X_MAX,
  parameter int unsigned Y_MAX = DEF_Y_MAX,
  parameter int unsigned X_RST = DEF_X_RST,
  parameter int unsigned Y_RST = DEF_Y_RST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_ready,
  input  logic [8:0] x_increment,
  input  logic [8:0] y_increment,
  input  logic       btn_left,
  input  logic       frame_start,
  output logic [9:0] ArrowPosX,
  output logic [9:0] ArrowPosY,
  output logic       click_valid,
  output logic [2:0] click_region,
  input  logic       click_ack
);

  localparam logic [11:0] X_MAX_W = 12'(X_MAX);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

  logic [9:0]  pend_x_q, pend_x_d;
  logic [9:0]  pend_y_q, pend_y_d;
  logic        btn_prev_q, btn_prev_d;
  logic [11:0] sum_x;
  logic [10:0] sum_y;
  logic [9:0]  new_x, new_y;
  logic [9:0]  disp_x, disp_y;
  logic [2:0]  region_now;
  logic        press_hit;

  click_state_e state_q;
  logic         click_valid_q;
  logic [2:0]   click_region_q;

  // Bit 11 / bit 10 of the sums act as the underflow flag.
  always_comb begin
    sum_x = {2'b00, pend_x_q} + {{3{x_increment[8]}}, x_increment};
    sum_y = {1'b0, pend_y_q} - {{2{y_increment[8]}}, y_increment};
    if (sum_x[11])              new_x = '0;
    else if (sum_x > X_MAX_W)   new_x = X_MAX_W[9:0];
    else                        new_x = sum_x[9:0];
    if (sum_y[10])              new_y = '0;
    else if (sum_y > Y_MAX_W)   new_y = Y_MAX_W[9:0];
    else                        new_y = sum_y[9:0];
  end

  always_comb begin
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    btn_prev_d = btn_prev_q;
    if (data_ready) begin
      pend_x_d   = new_x;
      pend_y_d   = new_y;
      btn_prev_d = btn_left;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x_q   <= 10'(X_RST);
      pend_y_q   <= 10'(Y_RST);
      btn_prev_q <= 1'b0;
    end else begin
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      btn_prev_q <= btn_prev_d;
    end
  end

`ifdef ARROW_FRAME_SYNC_EN
  logic [9:0] disp_x_q, disp_x_d;
  logic [9:0] disp_y_q, disp_y_d;

  // A packet landing on the frame pulse bypasses pend_* so it is not deferred.
  always_comb begin
    disp_x_d = disp_x_q;
    disp_y_d = disp_y_q;
    if (frame_start) begin
      disp_x_d = data_ready ? new_x : pend_x_q;
      disp_y_d = data_ready ? new_y : pend_y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_x_q <= 10'(X_RST);
      disp_y_q <= 10'(Y_RST);
    end else begin
      disp_x_q <= disp_x_d;
      disp_y_q <= disp_y_d;
    end
  end

  assign disp_x = disp_x_q;
  assign disp_y = disp_y_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign disp_x = pend_x_q;
  assign disp_y = pend_y_q;
`endif

  arrow_region_decode u_region (
    .pos_x  (disp_x),
    .pos_y  (disp_y),
    .region (region_now)
  );

  assign press_hit = data_ready && btn_left && !btn_prev_q &&
                     (region_now != REG_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      click_valid_q  <= 1'b0;
      click_region_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_hit) begin
            state_q        <= ST_HOLD;
            click_valid_q  <= 1'b1;
            click_region_q <= region_now;
          end
        end
        ST_HOLD: begin
          if (click_ack) begin
            if (press_hit) begin
              click_region_q <= region_now;
            end else begin
              state_q        <= ST_IDLE;
              click_valid_q  <= 1'b0;
              click_region_q <= '0;
            end
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          click_valid_q  <= 1'b0;
          click_region_q <= '0;
        end
      endcase
    end
  end

  assign ArrowPosX    = disp_x;
  assign ArrowPosY    = disp_y;
  assign click_valid  = click_valid_q;
  assign click_region = click_region_q;

endmodule

// File: tb/tb_arrow_ctrl.sv
// Directed bench for arrow_ctrl: table of clamp vectors plus hand-written
// click/commit/reset sequences; works with or without ARROW_FRAME_SYNC_EN.
module tb_arrow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_ready = 1'b0;
  logic [8:0] x_increment = '0;
  logic [8:0] y_increment = '0;
  logic       btn_left = 1'b0;
  logic       frame_start = 1'b0;
  logic       click_ack = 1'b0;
  logic [9:0] ArrowPosX, ArrowPosY;
  logic       click_valid;
  logic [2:0] click_region;

  int checks = 0;
  int failures = 0;

  arrow_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_ready   (data_ready),
    .x_increment  (x_increment),
    .y_increment  (y_increment),
    .btn_left     (btn_left),
    .frame_start  (frame_start),
    .ArrowPosX    (ArrowPosX),
    .ArrowPosY    (ArrowPosY),
    .click_valid  (click_valid),
    .click_region (click_region),
    .click_ack    (click_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dx;
    int dy;
    int ex;
    int ey;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pos(input string name, input int ex, input int ey);
    check({name, ".x"}, int'(ArrowPosX), ex);
    check({name, ".y"}, int'(ArrowPosY), ey);
  endtask

  // One-cycle packet; returns at the following negedge with outputs settled.
  task automatic pkt(input int dx, input int dy, input logic btn,
                     input logic fs, input logic ack);
    @(negedge clk);
    data_ready  = 1'b1;
    x_increment = 9'(dx);
    y_increment = 9'(dy);
    btn_left    = btn;
    frame_start = fs;
    click_ack   = ack;
    @(negedge clk);
    data_ready  = 1'b0;
    x_increment = '0;
    y_increment = '0;
    frame_start = 1'b0;
    click_ack   = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    click_ack = 1'b1;
    @(negedge clk);
    click_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_left = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int stable_bad;

    // Clamp walk; frame_start rides every packet, so the display tracks the
    // new sum in either build.
    vecs[0]  = '{-256,    0, 128, 284};
    vecs[1]  = '{-256,  255,   0,  29};
    vecs[2]  = '{   5,   26,   5,   3};
    vecs[3]  = '{-256, -256,   0, 259};
    vecs[4]  = '{   0,  255,   0,   4};
    vecs[5]  = '{   0,   10,   0,   0};
    vecs[6]  = '{   0,    0,   0,   0};
    vecs[7]  = '{ 255, -255, 255, 255};
    vecs[8]  = '{ 255, -255, 510, 510};
    vecs[9]  = '{ 255,  -70, 765, 580};
    vecs[10] = '{  15,    0, 780, 580};
    vecs[11] = '{ 255, -255, 783, 583};
    vecs[12] = '{  -1,    1, 782, 582};
    vecs[13] = '{   1,   -1, 783, 583};
    vecs[14] = '{   1,   -1, 783, 583};

    #12;
    check_pos("reset_pos", 384, 284);
    check("reset_valid", int'(click_valid), 0);
    check("reset_region", int'(click_region), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Deferred commit
    pkt(16, 4, 1'b0, 1'b0, 1'b0);
`ifdef ARROW_FRAME_SYNC_EN
    check_pos("pre_frame", 384, 284);
    check("pend_x", int'(dut.pend_x_q), 400);
    check("pend_y", int'(dut.pend_y_q), 280);
`else
    check_pos("pre_frame", 400, 280);
`endif
    frame();
    check_pos("post_frame", 400, 280);

    // Two packets between frames accumulate; then one coinciding with frame.
    pkt(10, 0, 1'b0, 1'b0, 1'b0);
    pkt(10, -20, 1'b0, 1'b1, 1'b0);
    check_pos("coincide", 420, 300);

    do_reset();
    check_pos("rereset", 384, 284);
    for (int i = 0; i < 15; i++) begin
      pkt(vecs[i].dx, vecs[i].dy, 1'b0, 1'b1, 1'b0);
      check_pos($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey);
      check($sformatf("vec%0d.valid", i), int'(click_valid), 0);
    end

    // Move into RETRY (overlapped by MESSAGE; lower code must win).
    do_reset();
    pkt(255, 255, 1'b0, 1'b1, 1'b0);
    pkt(61, 0, 1'b0, 1'b1, 1'b0);
    check_pos("at_retry", 700, 29);
    pkt(0, 0, 1'b1, 1'b1, 1'b0);
    check("retry_valid", int'(click_valid), 1);
    check("retry_region", int'(click_region), 2);
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (click_valid !== 1'b1 || click_region !== 3'd2) stable_bad++;
    end
    check("hold_stable_bad_cycles", stable_bad, 0);

    // Press over MESSAGE during HOLD is dropped.
    pkt(-80, 0, 1'b0, 1'b1, 1'b0);
    pkt(0, 0, 1'b1, 1'b1, 1'b0);
    check("drop_valid", int'(click_valid), 1);
    check("drop_region", int'(click_region), 2);
    ack();
    check("ack_valid", int'(click_valid), 0);
    ack();
    check("idle_ack_valid", int'(click_valid), 0);

    // MESSAGE click, then ack and a new press in the same cycle.
    pkt(0, 0, 1'b0, 1'b1, 1'b0);
    pkt(0, 0, 1'b1, 1'b1, 1'b0);
    check("msg_valid", int'(click_valid), 1);
    check("msg_region", int'(click_region), 6);
    pkt(80, 0, 1'b0, 1'b1, 1'b0);
    pkt(0, 0, 1'b1, 1'b1, 1'b1);
    check("ackpress_valid", int'(click_valid), 1);
    check("ackpress_region", int'(click_region), 2);
    ack();
    check("ack2_valid", int'(click_valid), 0);

    // Presses outside all rectangles, then held button entering LEVEL.
    pkt(-256, -255, 1'b0, 1'b1, 1'b0);
    check_pos("outside", 444, 284);
    pkt(0, 0, 1'b1, 1'b1, 1'b0);
    pkt(0, 0, 1'b1, 1'b1, 1'b0);
    pkt(0, 0, 1'b1, 1'b1, 1'b0);
    check("outside_valid", int'(click_valid), 0);
    pkt(-256, 255, 1'b1, 1'b1, 1'b0);
    pkt(-100, 0, 1'b1, 1'b1, 1'b0);
    pkt(0, 0, 1'b1, 1'b1, 1'b0);
    check_pos("at_level", 88, 29);
    check("held_valid", int'(click_valid), 0);
    pkt(0, 0, 1'b0, 1'b1, 1'b0);
    pkt(0, 0, 1'b1, 1'b1, 1'b0);
    check("level_valid", int'(click_valid), 1);
    check("level_region", int'(click_region), 1);

    // Asynchronous reset during HOLD.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(click_valid), 0);
    check("arst_region", int'(click_region), 0);
    check_pos("arst_pos", 384, 284);
    @(negedge clk);
    rst_n = 1'b1;
    btn_left = 1'b0;
    repeat (2) @(negedge clk);
    check("post_arst_valid", int'(click_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arrow_ctrl.md
# arrow_ctrl

Cursor controller for the mouse-arrow overlay layer. Consumes decoded PS/2 mouse packets, maintains the clamped arrow position `ArrowPosX`/`ArrowPosY` that drives the overlay, and commits position changes at frame boundaries to avoid tearing. It also turns left-button presses into single click commands, each tagged with the UI region under the arrow, and hands them to the game logic with a valid/ack handshake.

## Interface
Parameters:
- `X_MAX`, 783: largest legal `ArrowPosX`.
- `Y_MAX`, 583: largest legal `ArrowPosY`.
- `X_RST`, 384: `ArrowPosX` after reset.
- `Y_RST`, 284: `ArrowPosY` after reset.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_ready` in 1: one-cycle strobe; packet fields are valid.
- `x_increment` in 9: signed two's-complement X delta; positive moves right.
- `y_increment` in 9: signed Y delta; positive moves up, so screen Y decreases.
- `btn_left` in 1: left-button state in the packet; sampled only with `data_ready`.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `ArrowPosX` out 10: displayed arrow X.
- `ArrowPosY` out 10: displayed arrow Y.
- `click_valid` out 1: a click command is pending.
- `click_region` out 3: region code of the pending click.
- `click_ack` in 1: consumer accepts the pending click.

## Operation
- Pending position registers `pend_x`/`pend_y` hold the target position. On `data_ready`:
  - `sum_x` (12 bit) = zero-extended `pend_x` + sign-extended `x_increment`. If `sum_x[11]` is set, the result is 0. Otherwise, if `sum_x > X_MAX`, the result is `X_MAX`. Otherwise it is `sum_x`.
  - `sum_y` (11 bit) = `pend_y` − sign-extended `y_increment`. If `sum_y[10]` is set, the result is 0. Otherwise, if `sum_y > Y_MAX`, the result is `Y_MAX`. Otherwise it is `sum_y`.
  - Deltas of −256..+255 are all legal. The extreme cases are 0 − 256 → 0 and 783 + 255 → 783.
- Several packets arriving between frames accumulate in `pend_x`/`pend_y`.
- Region decode:
  - Combinational decode of the displayed `ArrowPosX`/`ArrowPosY` against the shared UI rectangles (bounds inclusive).
  - Codes: 0 NONE, 1 LEVEL, 2 RETRY, 3 RETRACT, 4 NEXT, 5 STEP, 6 MESSAGE.
  - If rectangles overlap, the lowest nonzero code wins.
- Button edge:
  - `btn_prev` updates only on `data_ready`.
  - A press is a `data_ready` cycle with `btn_left`=1 and `btn_prev`=0.
  - The region is taken from the displayed position in that cycle, before the packet's move is applied.
- Click FSM:
  - IDLE → HOLD on a press whose region is not 0. The region is latched into `click_region`.
  - Presses with region 0 are discarded.
  - HOLD → IDLE on `click_ack`.
  - Presses that arrive during HOLD are dropped.
  - If `click_ack` and a valid press occur in the same cycle, the FSM stays in HOLD and latches the new region.
- `click_ack` in IDLE is ignored.

## Timing
- Reset values:
  - `ArrowPosX`=`X_RST`, `ArrowPosY`=`Y_RST`, and `pend_*` equal the same values.
  - `click_valid`=0, `click_region`=0, `btn_prev`=0, FSM in IDLE.
- `pend_*` update on the edge after `data_ready`; latency is 1 cycle.
- Commit:
  - On `frame_start`, the displayed position loads `pend_*`.
  - If `data_ready` and `frame_start` coincide, the displayed position takes the newly computed value, so no packet is lost or delayed a frame.
- `click_valid`/`click_region` are registered and rise 1 cycle after the press cycle. They are held stable until acknowledged, and `click_valid` falls 1 cycle after `click_ack`.
- Reset asserted mid-operation clears everything immediately; a pending click is lost.

## Configuration
- `ARROW_FRAME_SYNC_EN` defined:
  - Commit happens only on `frame_start`, as above.
- Undefined:
  - `frame_start` is ignored.
  - The displayed position equals `pend_*`, so it updates 1 cycle after `data_ready`.
  - Region decode then uses the pre-packet value of `pend_*`.

## Structure
- The shared VGA parameter include holds:
  - the region code constants;
  - the UI rectangle bounds (`_EN_*_LEFT/RIGHT/UP/DOWN`);
  - the default screen limits and reset position.
- One sub-module, `arrow_region_decode`: purely combinational, takes the position and returns the 3-bit region code.
- The clamp arithmetic and the click FSM stay in `arrow_ctrl`.

## Test plan
- Reset, then `data_ready` with x=+16, y=+4, and no `frame_start`.
  - With the macro: pend=(400,280), display stays (384,284).
  - After `frame_start`: display is (400,280).
- Clamp at the lower edge: from (5,3), apply x=−256, y=−256 (down), then `frame_start`.
  - Display is (0,259).
  - Then apply y=+255 → Y=4; then y=+10 → Y=0.
- Clamp at the upper edge: from (780,580), apply x=+255, y=−255, then `frame_start` → display is (783,583).
- Press inside the RETRY rectangle (`btn_left` 0→1 across two packets).
  - `click_valid`=1 with region 2, held for 20 cycles without ack.
  - A second press during HOLD is dropped.
  - `click_ack` → `click_valid`=0 on the next cycle.
- Press outside all rectangles → `click_valid` stays 0.
  - `btn_left` held at 1 across 3 packets → exactly one press.
- `data_ready` and `frame_start` in the same cycle → display reflects the new sum on the next edge.
- Assert `rst_n` low during HOLD → `click_valid`=0 and position (384,284) immediately.
